int_issue_select_arbiter: RTL and testbench
===========================================

Name: int_issue_select_arbiter

Overview:
Per-cycle issue selector for the integer issue queue. Each cycle it picks up to ISSUE_WIDTH ready entries, using round-robin priority, and registers their indices for the integer issue stage. It obeys stall, clear, replay and selective flush from the scheduler and recovery logic. It sits between the wakeup/ready vector of the integer issue queue and the integer issue-stage pipeline register.

Parameters:
NUM_ENTRIES, 16, number of integer issue queue entries (power of two, >= ISSUE_WIDTH)
ISSUE_WIDTH, 2, number of grant lanes per cycle
IDX_W, $clog2(NUM_ENTRIES), entry index width (derived; do not override)
CNT_W, 32, width of the grant statistics counter

Ports:
clk  in  1  clock; all state updates on its rising edge
rst_n  in  1  asynchronous, active-low reset
stall  in  1  issue-stage stall from the controller
clear  in  1  issue-stage clear from the controller
replay  in  1  scheduler replays this cycle; no new selection
reqValid  in  NUM_ENTRIES  entry i is ready to issue
flushMask  in  NUM_ENTRIES  entry i is selectively flushed this cycle
grantValid  out  ISSUE_WIDTH  registered lane valid
grantPtr  out  ISSUE_WIDTH*IDX_W  registered entry index per lane; lane k at bits [k*IDX_W +: IDX_W]
selectedMask  out  NUM_ENTRIES  combinational: entries selected this cycle; the queue clears their ready bits
prioPtr  out  IDX_W  current round-robin start index
grantCount  out  CNT_W  saturating count of grants made

Behaviour:
- Reset (rst_n low, asynchronous): grantValid=0, grantPtr=0, prioPtr=0, grantCount=0. selectedMask=0 while rst_n is low.
- Candidate vector: cand = reqValid & ~flushMask.
- Selection (combinational):
  - Lane 0 takes the first cand bit found scanning upward from prioPtr, with wrap-around modulo NUM_ENTRIES.
  - Lane k takes the next cand bit after lane k-1's pick, in the same circular order.
  - Lanes with no remaining candidate are invalid.
  - Lanes fill in order: lane k valid implies lane k-1 valid.
- Mode priority per cycle: clear > stall > replay > normal.
  - clear: grantValid<=0; grantPtr held; prioPtr held; selectedMask=0; no count change.
  - stall: grantPtr held; grantValid[k] <= grantValid[k] & ~flushMask[grantPtr[k]]; prioPtr held; selectedMask=0.
  - replay (no stall, no clear): grantValid<=0; prioPtr held; selectedMask=0.
  - normal: grantValid/grantPtr load the selection; selectedMask = one bit per valid lane.
- prioPtr update in normal mode:
  - If any lane is granted, prioPtr <= (index of highest-numbered valid lane + 1) mod NUM_ENTRIES.
  - Otherwise prioPtr is unchanged.
- Latency: request at cycle t -> grant visible at cycle t+1. selectedMask is asserted in cycle t.
- A flushed entry is never granted in the same cycle its flushMask bit is set.
- grantCount: in normal mode, += popcount(selected lanes). Saturates at 2^CNT_W-1; no wrap.
- Boundaries:
  - reqValid all zero -> no grants, pointer unchanged.
  - Exactly one candidate -> lane 0 only.
  - Pointer at NUM_ENTRIES-1 with candidates at 0 and NUM_ENTRIES-1 -> lane0=NUM_ENTRIES-1, lane1=0, prioPtr<=1.
  - Reset asserted mid-stall -> all state cleared immediately; the held grant is lost.

Decomposition:
- The scheduler types package holds the shared types: the entry-index type (the existing issue-queue index type), ISSUE_WIDTH (the integer issue width constant) and NUM_ENTRIES (the integer issue queue size).
- Sub-module int_issue_rr_picker: purely combinational find-first-set from a start index with wrap.
  - Inputs: request vector, start index.
  - Outputs: found, index.
  - Instantiate ISSUE_WIDTH times, chained. Each stage's request vector is masked by the earlier picks and its start index is the previous pick + 1.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with reqValid=16'hFFFF -> all outputs 0 asynchronously; after release, next cycle grants lanes 0,1 = entries 0,1 and prioPtr=2.
- Round-robin wrap: prioPtr=15, reqValid bits {0,15} -> grantPtr lane0=15, lane1=0, prioPtr=1, grantCount+=2.
- Stall hold with flush: grants {3,5} registered, then stall=1 for 3 cycles with flushMask bit 5 in cycle 2 -> grantPtr stays {3,5}; grantValid goes 11 -> 01 (lane1 dropped); selectedMask=0 throughout; prioPtr unchanged.
- Replay/clear precedence: replay=1 with reqValid=16'h00F0 -> grantValid=0, selectedMask=0, prioPtr unchanged; clear=1 together with stall=1 -> grantValid=0.
- Flush same cycle: reqValid bits {2,4,6}, flushMask bit 4 -> grants {2,6}, selectedMask=16'h0044.
- Saturation: preload grantCount to 2^CNT_W-2, grant 2 lanes -> grantCount=2^CNT_W-1; further grants leave it unchanged.

Source files
------------

// File: rtl/int_issue_select_arbiter_pkg.sv
// Shared scheduler types for the integer issue path: queue size, issue width
// and the issue-queue entry index type.
package int_issue_select_arbiter_pkg;

   localparam int INT_IQ_ENTRIES  = 16;
   localparam int INT_ISSUE_WIDTH = 2;
   localparam int INT_IQ_IDX_W    = $clog2(INT_IQ_ENTRIES);

   typedef logic [INT_IQ_IDX_W-1:0] iq_idx_t;

endpackage

// File: rtl/int_issue_rr_picker.sv
// Circular find-first-set: returns the first set request bit at or after
// start, wrapping past the top entry back to zero.
module int_issue_rr_picker
   import int_issue_select_arbiter_pkg::*;
#(
   parameter int NUM_ENTRIES = INT_IQ_ENTRIES,
   parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
   input  logic [NUM_ENTRIES-1:0] req,
   input  logic [IDX_W-1:0]       start,
   output logic                   found,
   output logic [IDX_W-1:0]       idx
);

   logic [IDX_W-1:0] probe;

   // Scan offsets from farthest to nearest so the nearest hit is kept last.
   // NUM_ENTRIES is a power of two, so the IDX_W-bit add wraps naturally.
   always_comb begin
      found = 1'b0;
      idx   = start;
      probe = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         probe = start + IDX_W'(i);
         if (req[probe]) begin
            found = 1'b1;
            idx   = probe;
         end
      end
   end

endmodule

// File: rtl/int_issue_select_arbiter.sv
// Integer issue select: picks up to ISSUE_WIDTH ready entries per cycle in
// round-robin order and registers their indices for the issue stage.
// Interface contract: reqValid is a level "ready" vector, not a handshake.
// The cycle selectedMask shows an entry, the queue must drop that entry's
// ready bit; the registered grant for it appears on grantValid/grantPtr one
// cycle later. clear > stall > replay > normal select.
module int_issue_select_arbiter
   import int_issue_select_arbiter_pkg::*;
#(
   parameter int NUM_ENTRIES = INT_IQ_ENTRIES,
   parameter int ISSUE_WIDTH = INT_ISSUE_WIDTH,
   parameter int IDX_W       = $clog2(NUM_ENTRIES),
   parameter int CNT_W       = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         stall,
   input  logic                         clear,
   input  logic                         replay,
   input  logic [NUM_ENTRIES-1:0]       reqValid,
   input  logic [NUM_ENTRIES-1:0]       flushMask,
   output logic [ISSUE_WIDTH-1:0]       grantValid,
   output logic [ISSUE_WIDTH*IDX_W-1:0] grantPtr,
   output logic [NUM_ENTRIES-1:0]       selectedMask,
   output logic [IDX_W-1:0]             prioPtr,
   output logic [CNT_W-1:0]             grantCount
);

   logic [NUM_ENTRIES-1:0]       cand;
   logic [NUM_ENTRIES-1:0]       lane_req   [ISSUE_WIDTH];
   logic [NUM_ENTRIES-1:0]       lane_taken [ISSUE_WIDTH+1];
   logic [IDX_W-1:0]             lane_start [ISSUE_WIDTH];
   logic [IDX_W-1:0]             lane_idx   [ISSUE_WIDTH];
   logic [ISSUE_WIDTH-1:0]       lane_found;

   logic [ISSUE_WIDTH-1:0]       grant_valid_q, grant_valid_d;
   logic [ISSUE_WIDTH*IDX_W-1:0] grant_ptr_q, grant_ptr_d;
   logic [IDX_W-1:0]             prio_ptr_q, prio_ptr_d;
   logic [CNT_W-1:0]             grant_count_q, grant_count_d;
   logic [NUM_ENTRIES-1:0]       sel_mask;
   logic [CNT_W:0]               count_sum;
   logic [IDX_W-1:0]             last_idx;

   assign cand          = reqValid & ~flushMask;
   assign lane_taken[0] = '0;

   // Chained pickers: each lane skips earlier picks and starts just past the
   // previous lane's pick, so lanes fill in circular order.
   for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_lane
      assign lane_req[k] = cand & ~lane_taken[k];
      if (k == 0) begin : g_first
         assign lane_start[k] = prio_ptr_q;
      end else begin : g_next
         assign lane_start[k] = lane_idx[k-1] + IDX_W'(1);
      end
      assign lane_taken[k+1] = lane_taken[k] |
         (lane_found[k] ? (NUM_ENTRIES'(1) << lane_idx[k]) : '0);

      int_issue_rr_picker #(
         .NUM_ENTRIES (NUM_ENTRIES),
         .IDX_W       (IDX_W)
      ) u_picker (
         .req   (lane_req[k]),
         .start (lane_start[k]),
         .found (lane_found[k]),
         .idx   (lane_idx[k])
      );
   end

   // Mode decode and next-state for grants, priority pointer and counter.
   always_comb begin
      grant_valid_d = grant_valid_q;
      grant_ptr_d   = grant_ptr_q;
      prio_ptr_d    = prio_ptr_q;
      grant_count_d = grant_count_q;
      sel_mask      = '0;
      count_sum     = '0;
      last_idx      = prio_ptr_q;
      if (clear) begin
         grant_valid_d = '0;
      end else if (stall) begin
         // Held grants still honour selective flush of their entry.
         for (int k = 0; k < ISSUE_WIDTH; k++) begin
            grant_valid_d[k] = grant_valid_q[k] &
                               ~flushMask[grant_ptr_q[k*IDX_W +: IDX_W]];
         end
      end else if (replay) begin
         grant_valid_d = '0;
      end else begin
         grant_valid_d = lane_found;
         sel_mask      = lane_taken[ISSUE_WIDTH];
         count_sum     = {1'b0, grant_count_q};
         for (int k = 0; k < ISSUE_WIDTH; k++) begin
            grant_ptr_d[k*IDX_W +: IDX_W] = lane_found[k] ? lane_idx[k] : '0;
            if (lane_found[k]) begin
               last_idx  = lane_idx[k];
               count_sum = count_sum + (CNT_W+1)'(1);
            end
         end
         if (lane_found[0]) begin
            prio_ptr_d = last_idx + IDX_W'(1);
         end
         grant_count_d = count_sum[CNT_W] ? {CNT_W{1'b1}} : count_sum[CNT_W-1:0];
      end
   end

   // State registers; reset drops any held grant immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_valid_q <= '0;
         grant_ptr_q   <= '0;
         prio_ptr_q    <= '0;
         grant_count_q <= '0;
      end else begin
         grant_valid_q <= grant_valid_d;
         grant_ptr_q   <= grant_ptr_d;
         prio_ptr_q    <= prio_ptr_d;
         grant_count_q <= grant_count_d;
      end
   end

   assign grantValid   = grant_valid_q;
   assign grantPtr     = grant_ptr_q;
   assign prioPtr      = prio_ptr_q;
   assign grantCount   = grant_count_q;
   assign selectedMask = sel_mask & {NUM_ENTRIES{rst_n}};

endmodule

// File: tb/tb_int_issue_select_arbiter.sv
// Directed bench for int_issue_select_arbiter. A second instance with a
// 3-bit counter exercises counter saturation in a few cycles; its expected
// count is min(true count, 7).
module tb_int_issue_select_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, clear, replay;
   logic [15:0] req, flush;

   logic [1:0]  gv, gv_s;
   logic [7:0]  gptr, gptr_s;
   logic [15:0] sel, sel_s;
   logic [3:0]  prio, prio_s;
   logic [31:0] cnt;
   logic [2:0]  cnt_s;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        stall;
      logic        clear;
      logic        replay;
      logic [15:0] req;
      logic [15:0] flush;
      logic [15:0] exp_sel;
      logic [1:0]  exp_gv;
      logic [3:0]  exp_p0;
      logic [3:0]  exp_p1;
      logic [3:0]  exp_prio;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs[16];

   always #5 clk = ~clk;

   int_issue_select_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .clear        (clear),
      .replay       (replay),
      .reqValid     (req),
      .flushMask    (flush),
      .grantValid   (gv),
      .grantPtr     (gptr),
      .selectedMask (sel),
      .prioPtr      (prio),
      .grantCount   (cnt)
   );

   int_issue_select_arbiter #(.CNT_W(3)) dut_sat (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .clear        (clear),
      .replay       (replay),
      .reqValid     (req),
      .flushMask    (flush),
      .grantValid   (gv_s),
      .grantPtr     (gptr_s),
      .selectedMask (sel_s),
      .prioPtr      (prio_s),
      .grantCount   (cnt_s)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic s, input logic c, input logic r,
                               input logic [15:0] rq, input logic [15:0] fl,
                               input logic [15:0] es, input logic [1:0] eg,
                               input logic [3:0] e0, input logic [3:0] e1,
                               input logic [3:0] ep, input logic [31:0] ec);
      vec_t v;
      v.stall = s; v.clear = c; v.replay = r; v.req = rq; v.flush = fl;
      v.exp_sel = es; v.exp_gv = eg; v.exp_p0 = e0; v.exp_p1 = e1;
      v.exp_prio = ep; v.exp_cnt = ec;
      return v;
   endfunction

   function automatic logic [31:0] sat7(input logic [31:0] c);
      return (c > 32'd7) ? 32'd7 : c;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string tag, input logic [1:0] egv,
                             input logic [3:0] e0, input logic [3:0] e1,
                             input logic [3:0] ep, input logic [31:0] ec);
      chk({tag, ".gv"}, 32'(gv), 32'(egv));
      if (egv[0]) chk({tag, ".p0"}, 32'(gptr[3:0]), 32'(e0));
      if (egv[1]) chk({tag, ".p1"}, 32'(gptr[7:4]), 32'(e1));
      chk({tag, ".prio"}, 32'(prio), 32'(ep));
      chk({tag, ".cnt"}, cnt, ec);
      chk({tag, ".cnt_sat"}, 32'(cnt_s), sat7(ec));
   endtask

   initial begin
      // stall clear replay req flush | sel gv p0 p1 prio cnt
      vecs[0]  = mk(0, 0, 0, 16'hFFFF, 16'h0000, 16'h0003, 2'b11, 0, 1, 2, 2);
      vecs[1]  = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 2'b00, 0, 0, 2, 2);
      vecs[2]  = mk(0, 0, 0, 16'h0002, 16'h0000, 16'h0002, 2'b01, 1, 0, 2, 3);
      vecs[3]  = mk(0, 0, 0, 16'h0028, 16'h0000, 16'h0028, 2'b11, 3, 5, 6, 5);
      vecs[4]  = mk(1, 0, 0, 16'hFFFF, 16'h0000, 16'h0000, 2'b11, 3, 5, 6, 5);
      vecs[5]  = mk(1, 0, 0, 16'hFFFF, 16'h0020, 16'h0000, 2'b01, 3, 5, 6, 5);
      vecs[6]  = mk(1, 0, 0, 16'hFFFF, 16'h0000, 16'h0000, 2'b01, 3, 5, 6, 5);
      vecs[7]  = mk(0, 0, 1, 16'h00F0, 16'h0000, 16'h0000, 2'b00, 0, 0, 6, 5);
      vecs[8]  = mk(0, 0, 0, 16'h00F0, 16'h0000, 16'h00C0, 2'b11, 6, 7, 8, 7);
      vecs[9]  = mk(1, 1, 0, 16'hFFFF, 16'h0000, 16'h0000, 2'b00, 0, 0, 8, 7);
      vecs[10] = mk(0, 0, 0, 16'h0054, 16'h0010, 16'h0044, 2'b11, 2, 6, 7, 9);
      vecs[11] = mk(0, 0, 0, 16'h4000, 16'h0000, 16'h4000, 2'b01, 14, 0, 15, 10);
      vecs[12] = mk(0, 0, 0, 16'h8001, 16'h0000, 16'h8001, 2'b11, 15, 0, 1, 12);
      vecs[13] = mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 2'b00, 0, 0, 1, 12);
      vecs[14] = mk(0, 0, 0, 16'hFFFF, 16'hFFFF, 16'h0000, 2'b00, 0, 0, 1, 12);
      vecs[15] = mk(0, 1, 0, 16'h0003, 16'h0000, 16'h0000, 2'b00, 0, 0, 1, 12);

      // Reset state, with requests pending to show selectedMask is gated.
      rst_n = 1'b0; stall = 1'b0; clear = 1'b0; replay = 1'b0;
      req = 16'hFFFF; flush = 16'h0000;
      #3;
      chk("rst.sel", 32'(sel), 32'h0);
      chk("rst.gv", 32'(gv), 32'h0);
      chk("rst.ptr", 32'(gptr), 32'h0);
      chk("rst.prio", 32'(prio), 32'h0);
      chk("rst.cnt", cnt, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      req = 16'h0000;
      step();

      // Table: drive, check combinational select, clock, check registers.
      for (int i = 0; i < 16; i++) begin
         stall  = vecs[i].stall;
         clear  = vecs[i].clear;
         replay = vecs[i].replay;
         req    = vecs[i].req;
         flush  = vecs[i].flush;
         #1;
         chk($sformatf("v%0d.sel", i), 32'(sel), 32'(vecs[i].exp_sel));
         step();
         check_regs($sformatf("v%0d", i), vecs[i].exp_gv, vecs[i].exp_p0,
                    vecs[i].exp_p1, vecs[i].exp_prio, vecs[i].exp_cnt);
      end

      // Reset asserted while a grant is held by stall.
      stall = 1'b0; clear = 1'b0; replay = 1'b0;
      req = 16'h0300; flush = 16'h0000;
      step();
      check_regs("pre_stall", 2'b11, 8, 9, 10, 14);
      stall = 1'b1;
      step();
      check_regs("held", 2'b11, 8, 9, 10, 14);
      stall = 1'b0;
      req = 16'hFFFF;
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst.gv", 32'(gv), 32'h0);
      chk("midrst.ptr", 32'(gptr), 32'h0);
      chk("midrst.prio", 32'(prio), 32'h0);
      chk("midrst.cnt", cnt, 32'h0);
      chk("midrst.cnt_sat", 32'(cnt_s), 32'h0);
      chk("midrst.sel", 32'(sel), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("postrst.sel", 32'(sel), 32'h0003);
      step();
      check_regs("postrst", 2'b11, 0, 1, 2, 2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
